// File: rtl/mem_dma_master.sv
`default_nettype none
// ============================================================================
// Module   : mem_dma_master
// Purpose  : RAM bus initiator performing ascending block copy or byte fill.
// Revision : 1.0 - initial release
// ============================================================================
module mem_dma_master #(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 8
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              Start,
    input  logic              Mode,
    input  logic [ADDR_W-1:0] SrcAddr,
    input  logic [ADDR_W-1:0] DstAddr,
    input  logic [ADDR_W-1:0] Length,
    input  logic [DATA_W-1:0] FillValue,
    output logic              Busy,
    output logic              Done,
    output logic [ADDR_W-1:0] MemAddress,
    output logic              MemWE,
    output logic [DATA_W-1:0] MemWData,
    input  logic [DATA_W-1:0] MemRData
);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_RD   = 3'd1,
        S_LAT  = 3'd2,
        S_WR   = 3'd3,
        S_FIN  = 3'd4
    } state_t;

    localparam logic [ADDR_W-1:0] c_ADDR_ZERO = '0;
    localparam logic [ADDR_W-1:0] c_ADDR_ONE  = {{(ADDR_W-1){1'b0}}, 1'b1};

    state_t              r_state, w_state_nxt;
    logic [ADDR_W-1:0]   r_src, w_src_nxt;
    logic [ADDR_W-1:0]   r_dst, w_dst_nxt;
    logic [ADDR_W-1:0]   r_count, w_count_nxt;
    logic                r_mode, w_mode_nxt;
    logic [DATA_W-1:0]   r_fill, w_fill_nxt;
    logic                w_busy_nxt;
    logic                w_done_nxt;
    logic [ADDR_W-1:0]   w_addr_nxt;
    logic                w_we_nxt;
    logic [DATA_W-1:0]   w_wdata_nxt;

    // Outputs are registered from next-state values, so each state's bus
    // signals are already on the port during the cycle that state occupies.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_state    <= S_IDLE;
            r_src      <= '0;
            r_dst      <= '0;
            r_count    <= '0;
            r_mode     <= 1'b0;
            r_fill     <= '0;
            Busy       <= 1'b0;
            Done       <= 1'b0;
            MemAddress <= '0;
            MemWE      <= 1'b0;
            MemWData   <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_src      <= w_src_nxt;
            r_dst      <= w_dst_nxt;
            r_count    <= w_count_nxt;
            r_mode     <= w_mode_nxt;
            r_fill     <= w_fill_nxt;
            Busy       <= w_busy_nxt;
            Done       <= w_done_nxt;
            MemAddress <= w_addr_nxt;
            MemWE      <= w_we_nxt;
            MemWData   <= w_wdata_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_src_nxt   = r_src;
        w_dst_nxt   = r_dst;
        w_count_nxt = r_count;
        w_mode_nxt  = r_mode;
        w_fill_nxt  = r_fill;
        w_busy_nxt  = 1'b0;
        w_done_nxt  = 1'b0;
        w_addr_nxt  = MemAddress;
        w_we_nxt    = 1'b0;
        w_wdata_nxt = MemWData;

        case (r_state)
            S_IDLE: begin
                if (Start) begin
                    if (Length != c_ADDR_ZERO) begin
                        w_src_nxt   = SrcAddr;
                        w_dst_nxt   = DstAddr;
                        w_count_nxt = Length;
                        w_mode_nxt  = Mode;
                        w_fill_nxt  = FillValue;
                        w_busy_nxt  = 1'b1;
                        if (Mode) begin
                            w_state_nxt = S_WR;
                            w_addr_nxt  = DstAddr;
                            w_we_nxt    = 1'b1;
                            w_wdata_nxt = FillValue;
                        end else begin
                            w_state_nxt = S_RD;
                            w_addr_nxt  = SrcAddr;
                        end
                    end else begin
                        w_state_nxt = S_FIN;
                        w_done_nxt  = 1'b1;
                    end
                end
            end

            S_RD: begin
                w_state_nxt = S_LAT;
                w_busy_nxt  = 1'b1;
            end

            // MemWData doubles as the copy data latch: read data lands
            // directly in the register that drives the following write.
            S_LAT: begin
                w_state_nxt = S_WR;
                w_busy_nxt  = 1'b1;
                w_addr_nxt  = r_dst;
                w_we_nxt    = 1'b1;
                w_wdata_nxt = MemRData;
            end

            S_WR: begin
                w_src_nxt   = r_src + c_ADDR_ONE;
                w_dst_nxt   = r_dst + c_ADDR_ONE;
                w_count_nxt = r_count - c_ADDR_ONE;
                if (r_count == c_ADDR_ONE) begin
                    w_state_nxt = S_FIN;
                    w_done_nxt  = 1'b1;
                end else if (r_mode) begin
                    w_state_nxt = S_WR;
                    w_busy_nxt  = 1'b1;
                    w_addr_nxt  = r_dst + c_ADDR_ONE;
                    w_we_nxt    = 1'b1;
                    w_wdata_nxt = r_fill;
                end else begin
                    w_state_nxt = S_RD;
                    w_busy_nxt  = 1'b1;
                    w_addr_nxt  = r_src + c_ADDR_ONE;
                end
            end

            S_FIN: begin
                w_state_nxt = S_IDLE;
            end

            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

endmodule
`default_nettype wire

// File: tb/tb_mem_dma_master.sv
`default_nettype none
// ============================================================================
// Module   : tb_mem_dma_master
// Purpose  : Scoreboard bench for mem_dma_master with a behavioural RAM.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mem_dma_master;

    logic        CLK;
    logic        RST;
    logic        Start;
    logic        Mode;
    logic [15:0] SrcAddr;
    logic [15:0] DstAddr;
    logic [15:0] Length;
    logic [7:0]  FillValue;
    logic        Busy;
    logic        Done;
    logic [15:0] MemAddress;
    logic        MemWE;
    logic [7:0]  MemWData;
    logic [7:0]  MemRData;

    logic        bd_we;
    logic [15:0] bd_addr;
    logic [7:0]  bd_data;
    logic [7:0]  ram [0:65535];

    typedef struct packed {
        logic [15:0] a;
        logic [7:0]  d;
    } wr_t;

    wr_t wq[$];
    int  dq[$];
    int  cyc;
    int  n_checks;
    int  n_fail;

    mem_dma_master #(.ADDR_W(16), .DATA_W(8)) dut (
        .CLK        (CLK),
        .RST        (RST),
        .Start      (Start),
        .Mode       (Mode),
        .SrcAddr    (SrcAddr),
        .DstAddr    (DstAddr),
        .Length     (Length),
        .FillValue  (FillValue),
        .Busy       (Busy),
        .Done       (Done),
        .MemAddress (MemAddress),
        .MemWE      (MemWE),
        .MemWData   (MemWData),
        .MemRData   (MemRData)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    initial cyc = 0;
    always @(posedge CLK) cyc <= cyc + 1;

    // Synchronous RAM: write on WE at the edge, registered read data.
    always @(posedge CLK) begin
        if (bd_we)
            ram[bd_addr] <= bd_data;
        else if (MemWE)
            ram[MemAddress] <= MemWData;
        MemRData <= ram[MemAddress];
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Monitor: every write and every Done pulse is matched to the scoreboard.
    always @(negedge CLK) begin
        if (MemWE) begin
            if (wq.size() == 0) begin
                check("unexpected_write", 32'(MemAddress), 32'hFFFF_FFFF);
            end else begin
                wr_t e;
                e = wq.pop_front();
                check("write_addr", 32'(MemAddress), 32'(e.a));
                check("write_data", 32'(MemWData), 32'(e.d));
            end
        end
        if (Done) begin
            check("busy_in_fin", 32'(Busy), 32'd0);
            if (dq.size() == 0) begin
                check("unexpected_done", 32'(cyc), 32'hFFFF_FFFF);
            end else begin
                int e;
                e = dq.pop_front();
                check("done_latency", 32'(cyc + 1), 32'(e));
            end
        end
    end

    task automatic poke(input logic [15:0] a, input logic [7:0] d);
        @(negedge CLK);
        bd_we   = 1'b1;
        bd_addr = a;
        bd_data = d;
        @(negedge CLK);
        bd_we   = 1'b0;
    endtask

    task automatic exp_wr(input logic [15:0] a, input logic [7:0] d);
        wr_t e;
        e.a = a;
        e.d = d;
        wq.push_back(e);
    endtask

    // lat = cycles from the Start edge to the first edge that samples Done=1;
    // lat=0 means no Done pulse is expected.
    task automatic start_cmd(input logic m, input logic [15:0] s, input logic [15:0] d,
                             input logic [15:0] len, input logic [7:0] f, input int lat);
        @(negedge CLK);
        Mode      = m;
        SrcAddr   = s;
        DstAddr   = d;
        Length    = len;
        FillValue = f;
        Start     = 1'b1;
        if (lat > 0) dq.push_back(cyc + 1 + lat);
        @(negedge CLK);
        Start = 1'b0;
    endtask

    task automatic wait_idle(input string name);
        int budget;
        budget = 200;
        while ((wq.size() != 0 || dq.size() != 0) && budget > 0) begin
            @(negedge CLK);
            budget--;
        end
        check(name, 32'(budget == 0), 32'd0);
        repeat (2) @(negedge CLK);
    endtask

    initial begin
        logic seen_busy;
        int   seen;
        RST = 1'b0; Start = 1'b0; Mode = 1'b0; SrcAddr = '0; DstAddr = '0;
        Length = '0; FillValue = '0; bd_we = 1'b0; bd_addr = '0; bd_data = '0;
        n_checks = 0; n_fail = 0;
        #2 RST = 1'b1;
        #1;
        check("rst_busy",  32'(Busy), 32'd0);
        check("rst_done",  32'(Done), 32'd0);
        check("rst_we",    32'(MemWE), 32'd0);
        check("rst_addr",  32'(MemAddress), 32'd0);
        check("rst_wdata", 32'(MemWData), 32'd0);
        repeat (2) @(negedge CLK);
        RST = 1'b0;

        // Copy with an ignored Start pulse in the middle
        poke(16'h0100, 8'hAA); poke(16'h0101, 8'hBB);
        poke(16'h0102, 8'hCC); poke(16'h0103, 8'hDD);
        poke(16'h0204, 8'hEE); poke(16'h0033, 8'h77);
        exp_wr(16'h0200, 8'hAA); exp_wr(16'h0201, 8'hBB);
        exp_wr(16'h0202, 8'hCC); exp_wr(16'h0203, 8'hDD);
        start_cmd(1'b0, 16'h0100, 16'h0200, 16'd4, 8'h00, 13);
        repeat (2) @(negedge CLK);
        Mode = 1'b1; DstAddr = 16'h0400; Length = 16'd2; FillValue = 8'h99; Start = 1'b1;
        @(negedge CLK);
        Start = 1'b0;
        wait_idle("copy_timeout");
        check("copy_d0", 32'(ram[16'h0200]), 32'hAA);
        check("copy_d3", 32'(ram[16'h0203]), 32'hDD);
        check("copy_guard", 32'(ram[16'h0204]), 32'hEE);
        check("copy_src0", 32'(ram[16'h0100]), 32'hAA);
        check("copy_src3", 32'(ram[16'h0103]), 32'hDD);

        // Fill
        exp_wr(16'h0030, 8'h5A); exp_wr(16'h0031, 8'h5A); exp_wr(16'h0032, 8'h5A);
        start_cmd(1'b1, 16'h0000, 16'h0030, 16'd3, 8'h5A, 4);
        wait_idle("fill_timeout");
        check("fill_d0", 32'(ram[16'h0030]), 32'h5A);
        check("fill_d2", 32'(ram[16'h0032]), 32'h5A);
        check("fill_guard", 32'(ram[16'h0033]), 32'h77);

        // Fill across the address wrap
        exp_wr(16'hFFFE, 8'h11); exp_wr(16'hFFFF, 8'h11);
        exp_wr(16'h0000, 8'h11); exp_wr(16'h0001, 8'h11);
        start_cmd(1'b1, 16'h0000, 16'hFFFE, 16'd4, 8'h11, 5);
        wait_idle("wrap_timeout");
        check("wrap_fffe", 32'(ram[16'hFFFE]), 32'h11);
        check("wrap_ffff", 32'(ram[16'hFFFF]), 32'h11);
        check("wrap_0000", 32'(ram[16'h0000]), 32'h11);
        check("wrap_0001", 32'(ram[16'h0001]), 32'h11);

        // Zero length: Done only, never Busy
        seen_busy = 1'b0;
        start_cmd(1'b0, 16'h0100, 16'h0300, 16'd0, 8'h00, 1);
        for (int i = 0; i < 4; i++) begin
            seen_busy = seen_busy | Busy;
            @(negedge CLK);
        end
        check("zero_busy", 32'(seen_busy), 32'd0);
        wait_idle("zero_timeout");

        // Reset in the second write cycle of a copy
        for (int i = 0; i < 8; i++) poke(16'h0500 + 16'(i), 8'h40 + 8'(i));
        poke(16'h0601, 8'hCC);
        exp_wr(16'h0600, 8'h40);
        start_cmd(1'b0, 16'h0500, 16'h0600, 16'd8, 8'h00, 0);
        seen = 0;
        for (int i = 0; i < 40 && seen < 2; i++) begin
            @(posedge CLK);
            #1;
            if (MemWE) seen++;
        end
        check("rst_reach_wr2", 32'(seen), 32'd2);
        RST = 1'b1;
        #1;
        check("abort_busy", 32'(Busy), 32'd0);
        check("abort_we",   32'(MemWE), 32'd0);
        @(negedge CLK);
        RST = 1'b0;
        repeat (3) @(negedge CLK);
        check("abort_b0", 32'(ram[16'h0600]), 32'h40);
        check("abort_b1", 32'(ram[16'h0601]), 32'hCC);
        check("abort_wq", 32'(wq.size()), 32'd0);

        exp_wr(16'h0700, 8'h40);
        start_cmd(1'b0, 16'h0500, 16'h0700, 16'd1, 8'h00, 4);
        wait_idle("post_rst_timeout");
        check("post_rst_d0", 32'(ram[16'h0700]), 32'h40);

        // Overlapping ascending copy
        poke(16'h0010, 8'h01); poke(16'h0011, 8'h02); poke(16'h0012, 8'h03);
        exp_wr(16'h0011, 8'h01); exp_wr(16'h0012, 8'h01);
        start_cmd(1'b0, 16'h0010, 16'h0011, 16'd2, 8'h00, 7);
        wait_idle("overlap_timeout");
        check("overlap_11", 32'(ram[16'h0011]), 32'h01);
        check("overlap_12", 32'(ram[16'h0012]), 32'h01);

        check("final_wq", 32'(wq.size()), 32'd0);
        check("final_dq", 32'(dq.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/mem_dma_master.md
Name: mem_dma_master

Overview:
- Bus initiator for the 64 KiB synchronous RAM. That RAM writes on WE at the clock edge and returns registered read data one cycle after the address.
- Performs block copy (source range to destination range) or block fill (constant byte) on command from the CPU-side control logic.
- Sits between a control register bank and the RAM's Address/WE/DataIn/DataOut port. The RAM port is muxed to this block while Busy=1.

Parameters:
- ADDR_W, 16, RAM address width; pointers and length wrap modulo 2^ADDR_W.
- DATA_W, 8, RAM data width.

Ports:
- CLK  in  1  system clock, all state on rising edge.
- RST  in  1  asynchronous active-high reset.
- Start  in  1  command strobe, sampled only in IDLE.
- Mode  in  1  0 = copy, 1 = fill; sampled with Start.
- SrcAddr  in  ADDR_W  copy source start address; sampled with Start.
- DstAddr  in  ADDR_W  destination start address; sampled with Start.
- Length  in  ADDR_W  byte count; 0 = no transfer; sampled with Start.
- FillValue  in  DATA_W  fill byte; sampled with Start.
- Busy  out  1  transfer in progress.
- Done  out  1  one-cycle completion pulse.
- MemAddress  out  ADDR_W  RAM address.
- MemWE  out  1  RAM write enable.
- MemWData  out  DATA_W  to RAM DataIn.
- MemRData  in  DATA_W  from RAM DataOut; valid the cycle after its address was presented.

Behaviour:
- Reset (async, immediate): state IDLE; Busy=0, Done=0, MemWE=0, MemAddress=0, MemWData=0; internal pointers, count and data latch = 0.
- All outputs are registered.
- States: IDLE, RD, LAT, WR, FIN.
- IDLE:
  - Start=1 and Length≠0: load src/dst pointers, count=Length, mode and fill byte; Busy=1 from the next cycle.
  - Next state is RD for copy, WR for fill.
  - Start=1 and Length=0: go to FIN; no RAM access, MemWE never asserted.
- RD (copy only): MemAddress=src, MemWE=0; next LAT.
- LAT: RAM DataOut is now valid; capture MemRData into the data latch; MemWE=0; next WR.
- WR:
  - MemAddress=dst, MemWE=1, MemWData = data latch (copy) or FillValue (fill).
  - At the end of the cycle: src+1, dst+1 (wrap 0xFFFF→0x0000), count−1.
  - If the new count is 0, go to FIN; otherwise go to RD (copy) or stay in WR (fill).
- FIN: Done=1 for exactly one cycle, Busy=0 in this cycle, MemWE=0; next IDLE.
- Throughput: copy 3 cycles/byte; fill 1 cycle/byte.
- Latency from the Start edge to Done high:
  - copy: 3·Length+1 cycles;
  - fill: Length+1 cycles;
  - Length=0: 1 cycle.
- MemWE is high only in WR. MemAddress holds its last value in IDLE/FIN.
- Start while Busy=1 or in FIN is ignored; a new command needs Start in IDLE.
- Length=0xFFFF is legal: 65535 bytes, pointer wrap permitted mid-transfer.
- Overlap: copy is strictly ascending. With dst in (src, src+Length) the source is overwritten before it is read. This is defined behaviour, not guarded.
- Input changes after the Start edge have no effect on the running transfer.
- RST mid-transfer aborts immediately: MemWE drops asynchronously, no Done pulse, and bytes already written stay written.

Test Plan:
- Copy: RAM[0x0100..0x0103]=AA,BB,CC,DD; Start, Mode=0, Src=0x0100, Dst=0x0200, Length=4 → RAM[0x0200..0x0203]=AA,BB,CC,DD; Done pulses 13 cycles after the Start edge; exactly 4 MemWE cycles; source unchanged.
- Fill: Mode=1, Dst=0x0030, Length=3, FillValue=0x5A → RAM[0x30..0x32]=5A; MemWE high 3 consecutive cycles; Done 4 cycles after Start; RAM[0x33] untouched.
- Wrap: fill Dst=0xFFFE, Length=4, FillValue=0x11 → RAM[0xFFFE],[0xFFFF],[0x0000],[0x0001]=11.
- Zero length and ignored Start: Length=0 → Done 1 cycle after Start, Busy never 1, MemWE never 1. Start pulsed mid-copy with other operands → ignored; first transfer completes unchanged.
- Reset mid-op: copy Length=8, assert RST in the 2nd WR cycle → Busy=0, MemWE=0 before the next edge; only byte 0 copied; no Done; a subsequent Length=1 copy works normally.
- Overlap: RAM[0x10..0x12]=01,02,03; copy Src=0x10, Dst=0x11, Length=2 → RAM[0x11..0x12]=01,01.
